// File: rtl/fetch_prefetch.sv
// Instruction fetch unit with a prefetch queue, fixed-latency memory read pipeline
// and BR/JMP redirect handling; hands instructions to decode over valid/ready.
`timescale 1ns/1ps
module fetch_prefetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [3:0]        opCode_in,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic [8:0]        offset_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [ADDR_W-1:0] addr_out,
  output logic              mem_en,
  output logic              wea_out,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                pipe_v_q  [MEM_LAT];
  logic [ADDR_W-1:0]   pipe_pc_q [MEM_LAT];
  logic [DATA_W-1:0]   q_data_q  [DEPTH];
  logic [ADDR_W-1:0]   q_pc_q    [DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [PTR_W:0]      count_q, count_d;

  logic                br_taken_s, is_jmp_s, redirect_s;
  logic [ADDR_W-1:0]   br_target_s, target_s;
  logic [CNT_W-1:0]    inflight_s;
  logic                has_room_s, push_s, pop_s;

  // Redirect decode: BR needs a matching condition code, JMP always redirects.
  always_comb begin
    is_jmp_s    = (opCode_in == 4'b1100);
    br_taken_s  = (opCode_in == 4'b0000) && ((br_nzp & result_nzp) != 3'b000);
    redirect_s  = resolve_valid && (br_taken_s || is_jmp_s);
    br_target_s = resolve_pc + ADDR_W'(1) + {{(ADDR_W-9){offset_in[8]}}, offset_in};
    if (is_jmp_s) begin
      target_s = reg_in;
    end else begin
      target_s = br_target_s;
    end
  end

  // Reads in flight count against queue space so every arrival has a slot.
  always_comb begin
    inflight_s = {CNT_W{1'b0}};
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight_s = inflight_s + CNT_W'(pipe_v_q[i]);
    end
    has_room_s = ((CNT_W'(count_q) + inflight_s) < CNT_W'(DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a taken redirect always costs one FLUSH cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN, S_FLUSH: begin
        if (redirect_s) begin
          state_d = S_FLUSH;
        end else if (fetch_start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: issue only in RUN with space, and never in a redirect cycle.
  always_comb begin
    mem_en = 1'b0;
    case (state_q)
      S_RUN: begin
        if (has_room_s && !redirect_s) begin
          mem_en = 1'b1;
        end else begin
          mem_en = 1'b0;
        end
      end
      default: mem_en = 1'b0;
    endcase
  end

  // Fetch PC: redirect target wins over sequential increment.
  always_comb begin
    if (redirect_s) begin
      fetch_pc_d = target_s;
    end else if (mem_en) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= PC_RESET;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // In-flight read pipeline; a redirect kills every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_v_q[i]  <= 1'b0;
        pipe_pc_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      pipe_v_q[0]  <= mem_en;
      pipe_pc_q[0] <= fetch_pc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v_q[i]  <= pipe_v_q[i-1] && !redirect_s;
        pipe_pc_q[i] <= pipe_pc_q[i-1];
      end
    end
  end

  always_comb begin
    instr_valid = (count_q != {(PTR_W+1){1'b0}});
    pop_s       = instr_valid && instr_ready;
    push_s      = pipe_v_q[MEM_LAT-1] && !redirect_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W+1){1'b0}};
    end else if (redirect_s) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop_s) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Queue storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_data_q[tail_q] <= mem_rdata;
      q_pc_q[tail_q]   <= pipe_pc_q[MEM_LAT-1];
    end
  end

  assign addr_out  = fetch_pc_q;
  assign wea_out   = 1'b0;
  assign instr_out = q_data_q[head_q];
  assign pc        = instr_valid ? q_pc_q[head_q] : fetch_pc_q;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: reset, streaming, backpressure, BR/JMP redirects
// and PC wrap on a second instance reset to 0xFFFE.
`timescale 1ns/1ps
module tb_fetch_prefetch;

  logic        clk;
  logic        rst_n, rst_n1;
  logic        fetch_start, fetch_start1;
  logic [3:0]  opCode_in;
  logic        resolve_valid, resolve_valid1;
  logic [15:0] resolve_pc, reg_in;
  logic [8:0]  offset_in;
  logic [2:0]  br_nzp, result_nzp;
  logic [15:0] addr_out, addr_out1;
  logic        mem_en, mem_en1, wea_out, wea_out1;
  logic [15:0] mem_rdata, mem_rdata1;
  logic [15:0] instr_out, instr_out1;
  logic        instr_valid, instr_valid1;
  logic        instr_ready, instr_ready1;
  logic [15:0] pc, pc1;

  int total;
  int bad;

  fetch_prefetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .opCode_in(opCode_in),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .offset_in(offset_in),
    .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp), .addr_out(addr_out),
    .mem_en(mem_en), .wea_out(wea_out), .mem_rdata(mem_rdata), .instr_out(instr_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc)
  );

  fetch_prefetch #(.PC_RESET(16'hFFFE)) dut1 (
    .clk(clk), .rst_n(rst_n1), .fetch_start(fetch_start1), .opCode_in(opCode_in),
    .resolve_valid(resolve_valid1), .resolve_pc(resolve_pc), .offset_in(offset_in),
    .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp), .addr_out(addr_out1),
    .mem_en(mem_en1), .wea_out(wea_out1), .mem_rdata(mem_rdata1), .instr_out(instr_out1),
    .instr_valid(instr_valid1), .instr_ready(instr_ready1), .pc(pc1)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memories returning data equal to the address.
  always @(posedge clk) begin
    mem_rdata  <= mem_en  ? addr_out  : 16'hDEAD;
    mem_rdata1 <= mem_en1 ? addr_out1 : 16'hDEAD;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset0();
    fetch_start   = 1'b0;
    resolve_valid = 1'b0;
    opCode_in     = 4'b0101;
    rst_n         = 1'b0;
    next_cycle();
    next_cycle();
    rst_n         = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n1 = 1'b0;
    fetch_start = 1'b0; fetch_start1 = 1'b0;
    opCode_in = 4'b0101; resolve_valid = 1'b0; resolve_valid1 = 1'b0;
    resolve_pc = 16'h0000; reg_in = 16'h0000; offset_in = 9'h000;
    br_nzp = 3'b000; result_nzp = 3'b000;
    instr_ready = 1'b0; instr_ready1 = 1'b0;
    for (int c = 0; c < 5; c++) next_cycle();
    rst_n = 1'b1; rst_n1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #4;
      total++;
      if ({mem_en, instr_valid, wea_out, addr_out, pc} !== {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
        bad++;
        $display("FAIL reset0 c=%0d got en=%b v=%b wea=%b addr=%h pc=%h exp 0/0/0/0000/0000",
                 c, mem_en, instr_valid, wea_out, addr_out, pc);
      end
      total++;
      if ({mem_en1, instr_valid1, wea_out1, addr_out1, pc1} !== {1'b0, 1'b0, 1'b0, 16'hFFFE, 16'hFFFE}) begin
        bad++;
        $display("FAIL reset1 c=%0d got en=%b v=%b wea=%b addr=%h pc=%h exp 0/0/0/fffe/fffe",
                 c, mem_en1, instr_valid1, wea_out1, addr_out1, pc1);
      end
    end
  endtask

  task automatic test_stream();
    logic        ee, ev;
    logic [15:0] ea, ep;
    do_reset0();
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      if (c == 0) begin fetch_start = 1'b1; instr_ready = 1'b1; end
      #4;
      ee = (c >= 1);
      ea = (c >= 1) ? 16'(c - 1) : 16'h0000;
      ev = (c >= 3);
      ep = ev ? 16'(c - 3) : ea;
      total++;
      if ({mem_en, instr_valid, wea_out, addr_out, pc} !== {ee, ev, 1'b0, ea, ep}) begin
        bad++;
        $display("FAIL stream c=%0d got en=%b v=%b wea=%b addr=%h pc=%h exp en=%b v=%b addr=%h pc=%h",
                 c, mem_en, instr_valid, wea_out, addr_out, pc, ee, ev, ea, ep);
      end
      if (ev) begin
        total++;
        if (instr_out !== ep) begin
          bad++;
          $display("FAIL stream_instr c=%0d got=%h exp=%h", c, instr_out, ep);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic        ee, ev;
    logic [15:0] ea, ep;
    do_reset0();
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      if (c == 0) begin fetch_start = 1'b1; instr_ready = 1'b0; end
      if (c == 9) instr_ready = 1'b1;
      #4;
      if (c < 9) begin
        ee = (c >= 1) && (c <= 4);
        ea = (c == 0) ? 16'h0000 : ((c <= 4) ? 16'(c - 1) : 16'h0004);
        ep = (c >= 3) ? 16'h0000 : ea;
      end else begin
        ee = (c >= 10);
        ea = (c <= 10) ? 16'h0004 : 16'(c - 6);
        ep = 16'(c - 9);
      end
      ev = (c >= 3);
      total++;
      if ({mem_en, instr_valid, addr_out, pc} !== {ee, ev, ea, ep}) begin
        bad++;
        $display("FAIL backpressure c=%0d got en=%b v=%b addr=%h pc=%h exp en=%b v=%b addr=%h pc=%h",
                 c, mem_en, instr_valid, addr_out, pc, ee, ev, ea, ep);
      end
      if (ev) begin
        total++;
        if (instr_out !== ep) begin
          bad++;
          $display("FAIL backpressure_instr c=%0d got=%h exp=%h", c, instr_out, ep);
        end
      end
    end
  endtask

  task automatic test_br_taken();
    logic        ee [0:11];
    logic        ev [0:11];
    logic [15:0] ea [0:11];
    logic [15:0] ep [0:11];
    ee = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ea = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
           16'h0005, 16'h000F, 16'h000F, 16'h0010, 16'h0011, 16'h0012};
    ep = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0002,
           16'h0003, 16'h000F, 16'h000F, 16'h0010, 16'h000F, 16'h0010};
    do_reset0();
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if (c == 0) begin fetch_start = 1'b1; instr_ready = 1'b1; end
      if (c == 6) begin
        opCode_in = 4'b0000; resolve_pc = 16'h0010; offset_in = 9'h1FE;
        br_nzp = 3'b010; result_nzp = 3'b010; resolve_valid = 1'b1;
      end
      if (c == 7) resolve_valid = 1'b0;
      #4;
      total++;
      if ({mem_en, instr_valid, addr_out, pc} !== {ee[c], ev[c], ea[c], ep[c]}) begin
        bad++;
        $display("FAIL br_taken c=%0d got en=%b v=%b addr=%h pc=%h exp en=%b v=%b addr=%h pc=%h",
                 c, mem_en, instr_valid, addr_out, pc, ee[c], ev[c], ea[c], ep[c]);
      end
      if (ev[c]) begin
        total++;
        if (instr_out !== ep[c]) begin
          bad++;
          $display("FAIL br_taken_instr c=%0d got=%h exp=%h", c, instr_out, ep[c]);
        end
      end
    end
  endtask

  task automatic test_br_not_taken();
    logic        ev;
    logic [15:0] ea, ep;
    do_reset0();
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      if (c == 0) begin fetch_start = 1'b1; instr_ready = 1'b1; end
      if (c == 6) begin
        opCode_in = 4'b0000; resolve_pc = 16'h0010; offset_in = 9'h1FE;
        br_nzp = 3'b010; result_nzp = 3'b100; resolve_valid = 1'b1;
      end
      if (c == 7) resolve_valid = 1'b0;
      if (c == 8) begin
        opCode_in = 4'b0101; result_nzp = 3'b010; resolve_valid = 1'b1;
      end
      if (c == 9) resolve_valid = 1'b0;
      #4;
      ea = (c >= 1) ? 16'(c - 1) : 16'h0000;
      ev = (c >= 3);
      ep = ev ? 16'(c - 3) : ea;
      total++;
      if ({mem_en, instr_valid, addr_out, pc} !== {(c >= 1), ev, ea, ep}) begin
        bad++;
        $display("FAIL br_not_taken c=%0d got en=%b v=%b addr=%h pc=%h exp v=%b addr=%h pc=%h",
                 c, mem_en, instr_valid, addr_out, pc, ev, ea, ep);
      end
      if (ev) begin
        total++;
        if (instr_out !== ep) begin
          bad++;
          $display("FAIL br_not_taken_instr c=%0d got=%h exp=%h", c, instr_out, ep);
        end
      end
    end
  endtask

  task automatic test_jmp();
    logic        ee [0:8];
    logic        ev [0:8];
    logic [15:0] ea [0:8];
    logic [15:0] ep [0:8];
    ee = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ea = '{16'h0000, 16'h0000, 16'h0001, 16'h3000, 16'h3000, 16'h3001,
           16'h3002, 16'h3003, 16'h3004};
    ep = '{16'h0000, 16'h0000, 16'h0001, 16'h3000, 16'h3000, 16'h3001,
           16'h3000, 16'h3001, 16'h3002};
    do_reset0();
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      if (c == 0) begin fetch_start = 1'b1; instr_ready = 1'b1; end
      if (c == 2) begin opCode_in = 4'b1100; reg_in = 16'h3000; resolve_valid = 1'b1; end
      if (c == 3) resolve_valid = 1'b0;
      #4;
      total++;
      if ({mem_en, instr_valid, addr_out, pc} !== {ee[c], ev[c], ea[c], ep[c]}) begin
        bad++;
        $display("FAIL jmp c=%0d got en=%b v=%b addr=%h pc=%h exp en=%b v=%b addr=%h pc=%h",
                 c, mem_en, instr_valid, addr_out, pc, ee[c], ev[c], ea[c], ep[c]);
      end
      if (ev[c]) begin
        total++;
        if (instr_out !== ep[c]) begin
          bad++;
          $display("FAIL jmp_instr c=%0d got=%h exp=%h", c, instr_out, ep[c]);
        end
      end
    end
  endtask

  task automatic test_idle_redirect();
    logic        ee [0:5];
    logic        ev [0:5];
    logic [15:0] ea [0:5];
    logic [15:0] ep [0:5];
    ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ea = '{16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0101, 16'h0102};
    ep = '{16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0101, 16'h0100};
    do_reset0();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (c == 0) begin opCode_in = 4'b1100; reg_in = 16'h0100; resolve_valid = 1'b1; end
      if (c == 1) resolve_valid = 1'b0;
      if (c == 2) fetch_start = 1'b1;
      #4;
      total++;
      if ({mem_en, instr_valid, addr_out, pc} !== {ee[c], ev[c], ea[c], ep[c]}) begin
        bad++;
        $display("FAIL idle_redirect c=%0d got en=%b v=%b addr=%h pc=%h exp en=%b v=%b addr=%h pc=%h",
                 c, mem_en, instr_valid, addr_out, pc, ee[c], ev[c], ea[c], ep[c]);
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic        ev;
    logic [15:0] ea, ep;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin fetch_start1 = 1'b1; instr_ready1 = 1'b1; end
      #4;
      ea = (c >= 1) ? 16'hFFFE + 16'(c - 1) : 16'hFFFE;
      ev = (c >= 3);
      ep = ev ? 16'hFFFE + 16'(c - 3) : ea;
      total++;
      if ({mem_en1, instr_valid1, wea_out1, addr_out1, pc1} !== {(c >= 1), ev, 1'b0, ea, ep}) begin
        bad++;
        $display("FAIL pc_wrap c=%0d got en=%b v=%b wea=%b addr=%h pc=%h exp v=%b addr=%h pc=%h",
                 c, mem_en1, instr_valid1, wea_out1, addr_out1, pc1, ev, ea, ep);
      end
      if (ev) begin
        total++;
        if (instr_out1 !== ep) begin
          bad++;
          $display("FAIL pc_wrap_instr c=%0d got=%h exp=%h", c, instr_out1, ep);
        end
      end
    end
    // Asynchronous reset in the middle of a cycle must clear outputs at once.
    next_cycle();
    rst_n1 = 1'b0;
    #1;
    total++;
    if ({mem_en1, instr_valid1, addr_out1, pc1} !== {1'b0, 1'b0, 16'hFFFE, 16'hFFFE}) begin
      bad++;
      $display("FAIL async_reset got en=%b v=%b addr=%h pc=%h exp 0/0/fffe/fffe",
               mem_en1, instr_valid1, addr_out1, pc1);
    end
    fetch_start1 = 1'b0;
    next_cycle();
    rst_n1 = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_br_taken();
    test_br_not_taken();
    test_jmp();
    test_idle_redirect();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
